// File: rtl/uart_retrans_tx_if.sv
// Handshake, serial line and status bundle of the retransmitting UART transmitter.
// The master modport is the word source and far end; the slave modport is the transmitter.
interface uart_retrans_tx_if #(
    parameter int unsigned DATA_BITS = 7
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 signal;
    logic                 ack;
    logic                 request_resend;
    logic                 busy;
    logic [4:0]           resend_count;
    logic                 done;
    logic                 fail;

    modport master (
        output tx_data, tx_valid, ack, request_resend,
        input  tx_ready, signal, busy, resend_count, done, fail
    );

    modport slave (
        input  tx_data, tx_valid, ack, request_resend,
        output tx_ready, signal, busy, resend_count, done, fail
    );
endinterface

// File: rtl/uart_retrans_tx.sv
// Framed serial transmitter with ack / resend / timeout retransmission and retry limit.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the frame FSM.
module uart_retrans_tx #(
    parameter int unsigned DATA_BITS   = 7,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned ACK_TIMEOUT = 10,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input logic             clk,
    input logic             reset,
    uart_retrans_tx_if.slave bus
);
    localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitAck} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [4:0]           count_q, count_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 line_q, line_d;
    logic                 done, fail;
    logic                 take;
    logic [DATA_BITS-1:0] take_data;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_q, rd_q;
    logic [PW:0]          cnt_q;
    logic                 full, empty, push;

    assign full         = (cnt_q == (PW + 1)'(FIFO_DEPTH));
    assign empty        = (cnt_q == '0);
    assign push         = bus.tx_valid && !full;
    assign take         = (state_q == StIdle) && !empty;
    assign take_data    = mem_q[rd_q];
    assign bus.tx_ready = !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (take) rd_q <= rd_q + 1'b1;
            case ({push, take})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
`else
    // Sink for the FIFO depth, which only the FIFO build consumes.
    localparam int unsigned unused_fifo_depth = FIFO_DEPTH;

    assign take         = (state_q == StIdle) && bus.tx_valid;
    assign take_data    = bus.tx_data;
    assign bus.tx_ready = (state_q == StIdle);
`endif

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        timer_d   = timer_q;
        count_d   = count_q;
        data_d    = data_q;
        done      = 1'b0;
        fail      = 1'b0;
        case (state_q)
            StIdle: begin
                if (take) begin
                    data_d  = take_data;
                    count_d = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                bit_idx_d = '0;
                state_d   = StData;
            end
            StData: begin
                if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                    state_d = StParity;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            StParity: state_d = StStop;
            StStop: begin
                timer_d = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (bus.ack) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (bus.request_resend || timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    if (count_q < 5'(MAX_RETRIES)) begin
                        count_d = count_q + 1'b1;
                        state_d = StStart;
                    end else begin
                        fail    = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The line is registered, so it is driven from the state being entered.
        case (state_d)
            StStart:  line_d = 1'b0;
            StData:   line_d = data_d[bit_idx_d];
            StParity: line_d = ^data_d;
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_idx_q <= '0;
            timer_q   <= '0;
            count_q   <= '0;
            data_q    <= '0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            data_q    <= data_d;
            line_q    <= line_d;
        end
    end

    assign bus.signal       = line_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.resend_count = count_q;
    assign bus.done         = done;
    assign bus.fail         = fail;
endmodule

// File: tb/tb_uart_retrans_tx.sv
// Scoreboard bench for uart_retrans_tx: expected line bits are queued as words are
// driven and popped as the serial line is sampled on the falling clock edge.
module tb_uart_retrans_tx;
    localparam int unsigned DataBits   = 7;
    localparam int unsigned MaxRetries = 3;
    localparam int unsigned AckTimeout = 10;
    localparam int unsigned FifoDepth  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_retrans_tx_if #(.DATA_BITS(DataBits)) bus ();

    uart_retrans_tx #(
        .DATA_BITS  (DataBits),
        .MAX_RETRIES(MaxRetries),
        .ACK_TIMEOUT(AckTimeout),
        .FIFO_DEPTH (FifoDepth)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_q[$];
    int   gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference frame: start 0, data LSB first, even parity bit, stop 1.
    task automatic expect_frame(input logic [DataBits-1:0] w);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DataBits; i++) exp_q.push_back(w[i]);
        exp_q.push_back(^w);
        exp_q.push_back(1'b1);
    endtask

    task automatic push_word(input logic [DataBits-1:0] w);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then compares 10 line bits; ends in WAIT_ACK cycle 1.
    task automatic recv_frame(input string tag, output int idle);
        logic e;
        idle = 0;
        while (bus.signal !== 1'b0 && idle < 40) begin
            @(negedge clk);
            idle++;
        end
        check({tag, "_queued"}, (exp_q.size() >= 10) ? 32'd10 : exp_q.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            check($sformatf("%s_bit%0d", tag, i), bus.signal, e);
            @(negedge clk);
        end
    endtask

    task automatic do_ack(input string tag, input logic with_resend);
        bus.ack            = 1'b1;
        bus.request_resend = with_resend;
        #1;
        check({tag, "_done"}, bus.done, 1'b1);
        check({tag, "_nofail"}, bus.fail, 1'b0);
        @(negedge clk);
        bus.ack            = 1'b0;
        bus.request_resend = 1'b0;
        check({tag, "_done_off"}, bus.done, 1'b0);
        check({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.tx_valid       = 1'b0;
        bus.tx_data        = '0;
        bus.ack            = 1'b0;
        bus.request_resend = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_signal", bus.signal, 1'b1);
        check("rst_ready", bus.tx_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_fail", bus.fail, 1'b0);
        check("rst_count", bus.resend_count, 0);

        // Immediate ack.
        expect_frame(7'h07);
        push_word(7'h07);
        recv_frame("t1", gap);
        check("t1_wait_busy", bus.busy, 1'b1);
        check("t1_wait_line", bus.signal, 1'b1);
        do_ack("t1", 1'b0);
        check("t1_count", bus.resend_count, 0);
        check("t1_ready", bus.tx_ready, 1'b1);

        expect_frame(7'h00);
        push_word(7'h00);
        recv_frame("t2", gap);
        do_ack("t2", 1'b0);

        // Late ack, before the timeout; ack also beats a simultaneous resend request.
        expect_frame(7'h5A);
        push_word(7'h5A);
        recv_frame("t2b", gap);
        repeat (5) @(negedge clk);
        check("t2b_still_wait", bus.signal, 1'b1);
        do_ack("t2b", 1'b1);
        check("t2b_count", bus.resend_count, 0);

        // Resend request.
        expect_frame(7'h07);
        push_word(7'h07);
        recv_frame("t3", gap);
        bus.request_resend = 1'b1;
        expect_frame(7'h07);
        #1;
        check("t3_req_done", bus.done, 1'b0);
        check("t3_req_fail", bus.fail, 1'b0);
        @(negedge clk);
        bus.request_resend = 1'b0;
        recv_frame("t3r", gap);
        check("t3_gap", gap, 0);
        check("t3_count", bus.resend_count, 1);
        do_ack("t3r", 1'b0);
        check("t3_count_hold", bus.resend_count, 1);

        // No ack: three timeout retransmissions then fail.
        expect_frame(7'h07);
        push_word(7'h07);
        recv_frame("t4f0", gap);
        for (int r = 1; r <= MaxRetries; r++) begin
            expect_frame(7'h07);
            recv_frame($sformatf("t4f%0d", r), gap);
            check($sformatf("t4_gap%0d", r), gap, AckTimeout);
            check($sformatf("t4_count%0d", r), bus.resend_count, r);
        end
        for (int i = 1; i <= AckTimeout; i++) begin
            #1;
            check($sformatf("t4_fail_c%0d", i), bus.fail, (i == AckTimeout) ? 1'b1 : 1'b0);
            check($sformatf("t4_done_c%0d", i), bus.done, 1'b0);
            @(negedge clk);
        end
        check("t4_ready", bus.tx_ready, 1'b1);
        check("t4_busy", bus.busy, 1'b0);
        check("t4_count", bus.resend_count, MaxRetries);
        check("t4_fail_off", bus.fail, 1'b0);

        // Reset during the 3rd data bit of a retransmission.
        expect_frame(7'h2A);
        push_word(7'h2A);
        recv_frame("t5", gap);
        bus.request_resend = 1'b1;
        @(negedge clk);
        bus.request_resend = 1'b0;
        check("t5_count_pre", bus.resend_count, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_signal", bus.signal, 1'b1);
        check("t5_busy", bus.busy, 1'b0);
        check("t5_count", bus.resend_count, 0);
        check("t5_ready", bus.tx_ready, 1'b1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t5_quiet%0d", i), {bus.done, bus.fail, bus.signal}, 3'b001);
            @(negedge clk);
        end

`ifdef UART_TX_FIFO_EN
        // Fill the FIFO while the FSM is busy with a leading frame.
        expect_frame(7'h7F);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 7'h7F;
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            bus.tx_data = 7'(w);
            expect_frame(7'(w));
        end
        @(negedge clk);
        bus.tx_data = 7'h05;
        check("t6_full", bus.tx_ready, 1'b0);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        recv_frame("t6_7f", gap);
        do_ack("t6_7f", 1'b0);
        check("t6_still_full", bus.tx_ready, 1'b0);
        @(negedge clk);
        check("t6_ready_after_pop", bus.tx_ready, 1'b1);
        for (int w = 1; w <= 4; w++) begin
            recv_frame($sformatf("t6_w%0d", w), gap);
            do_ack($sformatf("t6_w%0d", w), 1'b0);
        end
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("end_idle", bus.signal, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
